// File: rtl/seq_mult_n_pkg.sv
// Shared types and limits for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/seq_mult_n_if.sv
// Request/response bundle of the sequential multiplier.
interface seq_mult_n_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output start, signed_mode, a, b,
    input  ready, busy, done, p
  );

  modport slave (
    input  start, signed_mode, a, b,
    output ready, busy, done, p
  );
endinterface

// File: rtl/seq_mult_n_add_nbit.sv
// Full-adder cell and the ripple adder built from it; results wrap modulo 2^N.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module add_nbit #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum
);
  logic [N-1:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < N - 1; g++) begin : g_fa
    fa_cell u_fa (
      .i_a (i_a[g]),
      .i_b (i_b[g]),
      .i_c (w_c[g]),
      .o_s (o_sum[g]),
      .o_c (w_c[g+1])
    );
  end

  // Carry out of the top bit is never needed, so only its sum is formed.
  assign o_sum[N-1] = i_a[N-1] ^ i_b[N-1] ^ w_c[N-1];
endmodule

// File: rtl/seq_mult_n.sv
// Sequential WIDTH x WIDTH multiplier: one partial product per cycle, signed
// operands handled by sign-extending a and subtracting the MSB term of b.
module seq_mult_n
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  seq_mult_n_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
    $error("seq_mult_n: WIDTH outside supported range");
  end

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic            r_sm;
  logic [PW-1:0]   r_p;

  logic            w_last;
  logic            w_sub;
  logic [PW-1:0]   w_pp;
  logic [PW-1:0]   w_addend;
  logic [PW-1:0]   w_sum;
  logic [PW-1:0]   w_a_ext;

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  // In signed mode the MSB of b carries weight -2^(W-1): add its term negated.
  assign w_sub    = r_sm & w_last;
  assign w_pp     = r_mplier[0] ? r_mcand : '0;
  assign w_addend = w_sub ? ~w_pp : w_pp;
  assign w_a_ext  = {{WIDTH{bus.signed_mode & bus.a[WIDTH-1]}}, bus.a};

  add_nbit #(.N(PW)) u_add (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .i_cin (w_sub),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (r_state)
      IDLE:    bus.ready = 1'b1;
      RUN:     bus.busy  = 1'b1;
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: bus.ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_sm     <= 1'b0;
      r_p      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= w_a_ext;
            r_mplier <= bus.b;
            r_sm     <= bus.signed_mode;
          end
        end
        RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) r_p <= w_sum;
        end
        default: ;
      endcase
    end
  end

  assign bus.p = r_p;
endmodule

// File: tb/tb_seq_mult_n.sv
// Scoreboard bench for seq_mult_n at WIDTH=8 and WIDTH=3.
module tb_seq_mult_n;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_mult_n_if #(.WIDTH(8)) bus8 ();
  seq_mult_n_if #(.WIDTH(3)) bus3 ();

  seq_mult_n #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  seq_mult_n #(.WIDTH(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  typedef struct {
    logic [63:0] p;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   m8 = 0;
  int   m3 = 0;
  int   n_done8 = 0;
  int   n_done3 = 0;
  logic [63:0] last_p8 = '0;
  logic [63:0] last_p3 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic sm);
    longint sa, sb;
    logic [63:0] mask;
    sa = longint'(a);
    sb = longint'(b);
    if (sm) begin
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
    end
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(sa * sb) & mask;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference timing: accept at edge k, done during cycle k+W, idle again after k+W+1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q8.delete();
      m8 <= 0;
    end else if (m8 == 0) begin
      if (bus8.start) begin
        q8.push_back('{p: ref_prod(8, 32'(bus8.a), 32'(bus8.b), bus8.signed_mode), cyc: cyc + 1 + 8});
        m8 <= 9;
      end
    end else begin
      m8 <= m8 - 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q3.delete();
      m3 <= 0;
    end else if (m3 == 0) begin
      if (bus3.start) begin
        q3.push_back('{p: ref_prod(3, 32'(bus3.a), 32'(bus3.b), bus3.signed_mode), cyc: cyc + 1 + 3});
        m3 <= 4;
      end
    end else begin
      m3 <= m3 - 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) last_p8 = '0;
    chk("ready8", 64'(bus8.ready), 64'(m8 == 0));
    chk("busy8",  64'(bus8.busy),  64'(m8 != 0));
    chk("done8",  64'(bus8.done),  64'(m8 == 1));
    if (bus8.done) begin
      n_done8++;
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("p8", 64'(bus8.p), e.p);
        chk("lat8", 64'(cyc), 64'(e.cyc));
        last_p8 = e.p;
      end
    end else begin
      chk("phold8", 64'(bus8.p), last_p8);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) last_p3 = '0;
    chk("ready3", 64'(bus3.ready), 64'(m3 == 0));
    chk("busy3",  64'(bus3.busy),  64'(m3 != 0));
    chk("done3",  64'(bus3.done),  64'(m3 == 1));
    if (bus3.done) begin
      n_done3++;
      if (q3.size() != 0) begin
        e = q3.pop_front();
        chk("p3", 64'(bus3.p), e.p);
        chk("lat3", 64'(cyc), 64'(e.cyc));
        last_p3 = e.p;
      end
    end else begin
      chk("phold3", 64'(bus3.p), last_p3);
    end
  end

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    @(posedge clk); #2;
    bus8.a = a; bus8.b = b; bus8.signed_mode = sm; bus8.start = 1'b1;
    @(posedge clk); #2;
    bus8.start = 1'b0;
    bus8.a = ~a; bus8.b = b + 8'd1; bus8.signed_mode = ~sm;
    repeat (10) @(posedge clk);
  endtask

  task automatic go3(input logic [2:0] a, input logic [2:0] b, input logic sm);
    @(posedge clk); #2;
    bus3.a = a; bus3.b = b; bus3.signed_mode = sm; bus3.start = 1'b1;
    @(posedge clk); #2;
    bus3.start = 1'b0;
    bus3.a = ~a; bus3.b = ~b;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.a = '0; bus8.b = '0;
    bus3.start = 1'b0; bus3.signed_mode = 1'b0; bus3.a = '0; bus3.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_p8", 64'(bus8.p), 64'd0);
    chk("rst_ready8", 64'(bus8.ready), 64'd1);
    chk("rst_p3", 64'(bus3.p), 64'd0);

    // Accept on the first edge after reset release.
    @(posedge clk); #2;
    rst = 1'b0;
    bus8.a = 8'd255; bus8.b = 8'd255; bus8.signed_mode = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #2;
    bus8.start = 1'b0; bus8.a = 8'd3; bus8.b = 8'd4;
    repeat (10) @(posedge clk);
    chk("p_ff_ff", 64'(bus8.p), 64'h0000_FE01);
    chk("first_done", 64'(n_done8), 64'd1);

    go8(8'h80, 8'h80, 1'b1);
    chk("p_m128sq", 64'(bus8.p), 64'h4000);
    go8(8'hFF, 8'h01, 1'b1);
    chk("p_m1x1", 64'(bus8.p), 64'hFFFF);
    go8(8'h00, 8'h00, 1'b0);
    go8(8'h00, 8'h5A, 1'b1);
    go8(8'h7F, 8'h80, 1'b1);
    go8(8'h80, 8'h7F, 1'b0);
    for (int i = 0; i < 12; i++) go8(8'($urandom), 8'($urandom), 1'($urandom));

    // Start re-pulsed mid-run must be ignored.
    d0 = n_done8;
    @(posedge clk); #2;
    bus8.a = 8'd12; bus8.b = 8'd34; bus8.signed_mode = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #2;
    bus8.start = 1'b0;
    repeat (2) @(posedge clk); #2;
    bus8.a = 8'd99; bus8.b = 8'd77; bus8.start = 1'b1;
    @(posedge clk); #2;
    bus8.start = 1'b0;
    repeat (12) @(posedge clk);
    chk("ign_p", 64'(bus8.p), 64'd408);
    chk("ign_dones", 64'(n_done8 - d0), 64'd1);

    // Reset during RUN aborts without a done pulse.
    @(posedge clk); #2;
    bus8.a = 8'd200; bus8.b = 8'd100; bus8.signed_mode = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #2;
    bus8.start = 1'b0;
    d0 = n_done8;
    repeat (3) @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_p", 64'(bus8.p), 64'd0);
    chk("abort_ready", 64'(bus8.ready), 64'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    chk("abort_nodone", 64'(n_done8 - d0), 64'd0);
    go8(8'd200, 8'd100, 1'b0);
    chk("after_abort_p", 64'(bus8.p), 64'd20000);

    // start held high: back-to-back with operands changing every cycle.
    d0 = n_done8;
    @(posedge clk); #2;
    bus8.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.signed_mode = 1'($urandom);
      @(posedge clk); #2;
    end
    bus8.start = 1'b0;
    repeat (12) @(posedge clk);
    chk("b2b_dones", 64'(n_done8 - d0), 64'd4);

    // WIDTH=3 exhaustive unsigned, then a few signed corners.
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        go3(3'(a), 3'(b), 1'b0);
    chk("p3_7x7", 64'(bus3.p), 64'd49);
    go3(3'b100, 3'b100, 1'b1);
    chk("p3_m4sq", 64'(bus3.p), 64'd16);
    go3(3'b111, 3'b011, 1'b1);
    go3(3'b011, 3'b100, 1'b1);
    chk("done3_count", 64'(n_done3), 64'd67);

    repeat (4) @(posedge clk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q3_drained", 64'(q3.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
